bus_rr_sched: RTL and testbench

- Round-robin scheduler that shares the single bus between `drvrs` driver FIFOs.
- Each cycle it can:
  - observe each FIFO's pending flag;
  - grant one requester fairly;
  - pop that FIFO's head packet;
  - decode the destination ID from the packet's top 8 bits;
  - push the packet to the destination FIFO(s), including broadcast.
- It is the sequencing core that sits between the driver/monitor-side FIFO interface and the shared bus data path.

---
 rtl/bus_rr_sched.sv | 123 ++++++++++++
 tb/tb_bus_rr_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_sched.sv
// Round-robin scheduler for a shared bus: grants one pending driver FIFO, pops its head packet,
// and routes it to the destination FIFO(s) selected by the packet's top byte.
module bus_rr_sched #(
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 16,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]           pop,
  output logic [drvrs-1:0]           push,
  output logic [pckg_sz-1:0]         D_push,
  output logic                       busy,
  output logic [$clog2(drvrs)-1:0]   grant_id,
  output logic [15:0]                drop_cnt
);

  localparam int GW = $clog2(drvrs);

  typedef enum logic [1:0] {StIdle, StCapture, StRoute} state_e;

  state_e             r_state;
  state_e             w_state_d;
  logic [GW-1:0]      r_ptr;
  logic [GW-1:0]      r_grant;
  logic [GW-1:0]      w_sel;
  logic [GW-1:0]      w_idx;
  logic               w_any;
  logic               w_take;
  logic [pckg_sz-1:0] r_data;
  logic [15:0]        r_drop;
  logic [7:0]         w_dest;
  logic [drvrs-1:0]   w_self;
  logic [drvrs-1:0]   w_route;
  logic               w_deliver;
  logic               w_drop;

  assign w_any  = |pndng;
  assign w_take = pndng[r_grant];
  assign w_dest = r_data[pckg_sz-1 -: 8];

  // Scan from the farthest offset down so the nearest pending driver after r_ptr wins.
  always_comb begin
    int idx;
    w_sel = r_ptr;
    w_idx = r_ptr;
    for (int k = drvrs; k >= 1; k--) begin
      idx = int'(r_ptr) + k;
      if (idx >= drvrs) idx = idx - drvrs;
      w_idx = GW'(idx);
      if (pndng[w_idx]) w_sel = w_idx;
    end
  end

  // Destination decode of the latched packet.
  always_comb begin
    w_self          = '0;
    w_self[r_grant] = 1'b1;
    w_route         = '0;
    w_deliver       = 1'b0;
    if (w_dest == broadcast) begin
      w_route   = ~w_self;
      w_deliver = 1'b1;
    end else if (int'(w_dest) < drvrs && int'(w_dest) != int'(r_grant)) begin
      for (int i = 0; i < drvrs; i++) w_route[i] = (int'(w_dest) == i);
      w_deliver = 1'b1;
    end
  end

  assign w_drop = (r_state == StRoute) && !w_deliver;

  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:    if (w_any) w_state_d = StCapture;
      StCapture: w_state_d = w_take ? StRoute : StIdle;
      StRoute:   w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr   <= GW'(drvrs - 1);
      r_grant <= '0;
      r_data  <= '0;
      r_drop  <= '0;
    end else begin
      if (r_state == StIdle && w_any) r_grant <= w_sel;
      if (r_state == StCapture && w_take) begin
        r_data <= D_pop[int'(r_grant)*pckg_sz +: pckg_sz];
        r_ptr  <= r_grant;
      end
      if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
    end
  end

  // Strobes are masked while reset is high so an aborted transfer never pops or pushes.
  always_comb begin
    pop  = '0;
    push = '0;
    if (!reset) begin
      case (r_state)
        StCapture: if (w_take) pop[r_grant] = 1'b1;
        StRoute:   push = w_route;
        default:   ;
      endcase
    end
  end

  assign busy     = (r_state != StIdle);
  assign grant_id = r_grant;
  assign drop_cnt = r_drop;
  assign D_push   = r_data;

endmodule

// File: tb/tb_bus_rr_sched.sv
// Scoreboard bench for bus_rr_sched: a transaction-level model queues expected pop/push events,
// and a monitor compares them whenever the DUT strobes pop or push.
module tb_bus_rr_sched;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  pndng;
  logic [63:0] d_pop;
  logic [3:0]  pop;
  logic [3:0]  push;
  logic [15:0] d_push;
  logic        busy;
  logic [1:0]  grant_id;
  logic [15:0] drop_cnt;

  bus_rr_sched #(.drvrs(N), .pckg_sz(16), .broadcast(8'hFF)) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .D_pop    (d_pop),
    .pop      (pop),
    .push     (push),
    .D_push   (d_push),
    .busy     (busy),
    .grant_id (grant_id),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_push;
    int          cyc;
    logic [3:0]  mask;
    logic [15:0] data;
    int          grant;
    int          drop;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  int          m_ptr  = N - 1;
  int          m_drop = 0;
  logic [15:0] m_last = '0;
  logic [15:0] stim [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (pop != 4'd0 || push != 4'd0) begin
      check("pop_push_overlap", {31'd0, (|pop) & (|push)}, 32'd0);
      check("pop_onehot", {31'd0, $countones(pop) <= 1}, 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {24'd0, pop, push}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind", {31'd0, |push}, {31'd0, mon_e.is_push});
        check("event_cycle", cyc, mon_e.cyc);
        if (mon_e.is_push) begin
          check("push_mask", {28'd0, push}, {28'd0, mon_e.mask});
          check("d_push", {16'd0, d_push}, {16'd0, mon_e.data});
        end else begin
          check("pop_mask", {28'd0, pop}, {28'd0, mon_e.mask});
          check("grant_id", {30'd0, grant_id}, mon_e.grant);
          check("drop_cnt", {16'd0, drop_cnt}, mon_e.drop);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    pndng = 4'($urandom);
    d_pop = {$urandom, $urandom};
  endtask

  task automatic drive_stim();
    for (int i = 0; i < N; i++) d_pop[i*16 +: 16] = stim[i];
  endtask

  task automatic check_reset_regs(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_grant"}, {30'd0, grant_id}, 32'd0);
    check({tag, "_dpush"}, {16'd0, d_push}, 32'd0);
    check({tag, "_drop"}, {16'd0, drop_cnt}, 32'd0);
  endtask

  // One scheduler transaction window, starting with the DUT idle.
  task automatic window(input logic [3:0] mask, input bit withdraw, input bit rst_abort);
    int          g;
    int          k;
    int          idx;
    logic [7:0]  dest;
    logic [3:0]  pm;
    exp_t        e;
    if (mask == 4'd0) begin
      pndng = 4'd0;
      d_pop = {$urandom, $urandom};
      step();
      return;
    end
    g = -1;
    for (int j = 1; j <= N; j++) begin
      idx = (m_ptr + j) % N;
      if (g < 0 && mask[idx[1:0]]) g = idx;
    end
    k     = cyc;
    pndng = mask;
    drive_stim();
    step();
    if (rst_abort) begin
      reset = 1'b1;
      step();
      check_reset_regs("abort");
      m_ptr  = N - 1;
      m_drop = 0;
      m_last = '0;
      rand_inputs();
      step();
      reset = 1'b0;
      return;
    end
    if (withdraw) begin
      pndng = 4'($urandom) & ~(4'b0001 << g);
      d_pop = {$urandom, $urandom};
      step();
      return;
    end
    pndng = 4'($urandom) | (4'b0001 << g);
    d_pop = {$urandom, $urandom};
    d_pop[g*16 +: 16] = stim[g];
    e = '{is_push: 1'b0, cyc: k + 1, mask: 4'b0001 << g, data: 16'd0, grant: g, drop: m_drop};
    exp_q.push_back(e);
    m_ptr  = g;
    m_last = stim[g];
    dest   = stim[g][15:8];
    if (dest == 8'hFF) pm = 4'b1111 & ~(4'b0001 << g);
    else if (int'(dest) < N && int'(dest) != g) pm = 4'b0001 << dest;
    else pm = 4'd0;
    if (pm == 4'd0) begin
      if (m_drop < 16'hFFFF) m_drop++;
    end else begin
      e = '{is_push: 1'b1, cyc: k + 2, mask: pm, data: stim[g], grant: g, drop: 0};
      exp_q.push_back(e);
    end
    step();
    rand_inputs();
    step();
  endtask

  initial begin
    int r;
    logic [3:0] mask;
    reset = 1'b1;
    rand_inputs();
    repeat (5) begin
      step();
      check("rst_pop", {28'd0, pop}, 32'd0);
      check("rst_push", {28'd0, push}, 32'd0);
      check_reset_regs("rst");
      rand_inputs();
    end
    reset = 1'b0;

    // All requesting, all valid destinations: grants rotate 0,1,2,3,0.
    for (int i = 0; i < N; i++) stim[i] = {8'((i + 1) % N), 8'(i * 17)};
    repeat (5) window(4'b1111, 1'b0, 1'b0);

    stim[1] = 16'h02AB;
    window(4'b0010, 1'b0, 1'b0);
    stim[2] = 16'hFF5A;
    window(4'b0100, 1'b0, 1'b0);
    stim[0] = 16'h0711;
    window(4'b0001, 1'b0, 1'b0);
    stim[3] = 16'h0322;
    window(4'b1000, 1'b0, 1'b0);

    // Withdrawn request leaves the pointer alone, so driver 1 still wins next.
    stim[1] = 16'h0012;
    window(4'b0010, 1'b1, 1'b0);
    window(4'b1110, 1'b0, 1'b0);

    stim[2] = 16'h0155;
    window(4'b0100, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) stim[i] = {8'((i + 2) % N), 8'(i)};
    window(4'b1111, 1'b0, 1'b0);

    repeat (300) begin
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(0, 9);
        if (r < 6)      stim[i] = {8'($urandom_range(0, N - 1)), 8'($urandom)};
        else if (r < 8) stim[i] = {8'hFF, 8'($urandom)};
        else            stim[i] = {8'($urandom_range(4, 254)), 8'($urandom)};
      end
      mask = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
      window(mask, $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
    end

    pndng = 4'd0;
    step();
    step();
    check("final_drop_cnt", {16'd0, drop_cnt}, m_drop);
    check("final_d_push", {16'd0, d_push}, {16'd0, m_last});
    check("final_busy", {31'd0, busy}, 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
